// File: rtl/img_cpu_writer.sv
// img_cpu_writer: loads CPU pixel words into the SDRAM write FIFO over a valid/ack handshake
module img_cpu_writer #(
    parameter int ASIZE = 23,
    parameter int DSIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pixel_valid,
    input  logic [DSIZE-1:0] pixel_data,
    output logic             ack,
    input  logic [ASIZE-1:0] start_addr,
    input  logic [ASIZE-1:0] max_addr,
    output logic [DSIZE-1:0] wr_data,
    output logic             wr_req,
    output logic             wr_load,
    input  logic             wr_full,
    output logic             img_done,
    output logic [ASIZE-1:0] word_count,
    output logic [3:0]       curr_state
);
    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        CLEAR        = 4'd1,
        WAIT_VALID   = 4'd2,
        PUSH         = 4'd3,
        WAIT_RELEASE = 4'd4,
        DONE         = 4'd5
    } state_t;

    state_t           state_q, state_d;
    logic [ASIZE-1:0] curr_addr_q, curr_addr_d;
    logic [ASIZE-1:0] max_q, max_d;
    logic [ASIZE-1:0] word_count_q, word_count_d;
    logic [DSIZE-1:0] wr_data_q, wr_data_d;
    logic             ack_q, ack_d;
    logic             wr_req_q, wr_req_d;
    logic             wr_load_q, wr_load_d;
    logic             img_done_q, img_done_d;

    // Next state and registered outputs derived from the upcoming state
    always_comb begin
        state_d      = state_q;
        curr_addr_d  = curr_addr_q;
        max_d        = max_q;
        word_count_d = word_count_q;
        wr_data_d    = wr_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    max_d        = max_addr;
                    curr_addr_d  = start_addr;
                    word_count_d = '0;
                    state_d      = (max_addr <= start_addr) ? DONE : CLEAR;
                end
            end
            CLEAR:      state_d = WAIT_VALID;
            WAIT_VALID: begin
                if (!start) state_d = IDLE;
                else if (pixel_valid) begin
                    wr_data_d = pixel_data;
                    state_d   = PUSH;
                end
            end
            PUSH: begin
                if (!wr_full) begin
                    curr_addr_d  = curr_addr_q + 1'b1;
                    word_count_d = word_count_q + 1'b1;
                    state_d      = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!pixel_valid)
                    state_d = !start ? IDLE : (curr_addr_q == max_q) ? DONE : WAIT_VALID;
            end
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        ack_d      = state_d == WAIT_RELEASE;
        wr_req_d   = state_q == PUSH && state_d == WAIT_RELEASE;
        wr_load_d  = state_d == CLEAR;
        img_done_d = state_d == DONE;
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            curr_addr_q  <= '0;
            max_q        <= '0;
            word_count_q <= '0;
            wr_data_q    <= '0;
            ack_q        <= 1'b0;
            wr_req_q     <= 1'b0;
            wr_load_q    <= 1'b0;
            img_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            curr_addr_q  <= curr_addr_d;
            max_q        <= max_d;
            word_count_q <= word_count_d;
            wr_data_q    <= wr_data_d;
            ack_q        <= ack_d;
            wr_req_q     <= wr_req_d;
            wr_load_q    <= wr_load_d;
            img_done_q   <= img_done_d;
        end
    end

    assign ack        = ack_q;
    assign wr_req     = wr_req_q;
    assign wr_load    = wr_load_q;
    assign img_done   = img_done_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;
    assign curr_state = state_q;
endmodule
